// File: rtl/nn_weight_loader.sv
// Streams signed weight bytes into the wide weight RAM: packs BPW bytes per word, writes NWORDS words
// from BASE_ADDR, then checks a trailing 8-bit checksum. busy covers the whole load.
module nn_weight_loader #(
  parameter int WWIDTH     = 8,
  parameter int WORD_BITS  = 256,
  parameter int NWORDS     = 2,
  parameter int ADDR_WIDTH = 4,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WWIDTH-1:0]     in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_BITS-1:0]  mem_wdata,
  output logic                  mem_we,
  output logic                  busy,
  output logic                  done,
  output logic                  cksum_err,
  output logic [2:0]            state_dbg
);

  localparam int BPW = WORD_BITS / WWIDTH;
  localparam int BCW = $clog2(BPW);

  typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_CHECK, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [BCW-1:0]        byte_cnt_q, byte_cnt_d;
  logic [ADDR_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_BITS-1:0]  wdata_q, wdata_d;
  logic [WWIDTH-1:0]     sum_q, sum_d;
  logic                  in_ready_q, in_ready_d;
  logic                  we_q, we_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  cksum_err_q, cksum_err_d;
  logic                  accept;

  // Handshake: a byte moves on any cycle where in_valid && in_ready; in_ready is a flop, so it never
  // depends combinationally on in_valid.
  assign accept = in_valid && in_ready_q;

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    word_cnt_d  = word_cnt_q;
    mem_addr_d  = mem_addr_q;
    wdata_d     = wdata_q;
    sum_d       = sum_q;
    cksum_err_d = cksum_err_q;
    if (abort) begin
      if (state_q != S_IDLE) state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d     = S_RECV;
            byte_cnt_d  = '0;
            word_cnt_d  = '0;
            sum_d       = '0;
            mem_addr_d  = ADDR_WIDTH'(BASE_ADDR);
            cksum_err_d = 1'b0;
          end
        end
        S_RECV: begin
          if (accept) begin
            // Oldest byte ends up in the low lane once the word is full.
            wdata_d    = {in_data, wdata_q[WORD_BITS-1:WWIDTH]};
            sum_d      = sum_q + in_data;
            byte_cnt_d = byte_cnt_q + BCW'(1);
            if (byte_cnt_q == BCW'(BPW - 1)) state_d = S_WRITE;
          end
        end
        S_WRITE: begin
          byte_cnt_d = '0;
          if (word_cnt_q == ADDR_WIDTH'(NWORDS - 1)) begin
            state_d = S_CHECK;
          end else begin
            word_cnt_d = word_cnt_q + ADDR_WIDTH'(1);
            mem_addr_d = mem_addr_q + ADDR_WIDTH'(1);
            state_d    = S_RECV;
          end
        end
        S_CHECK: begin
          if (accept) begin
            cksum_err_d = (in_data != sum_q);
            state_d     = S_DONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    in_ready_d = (state_d == S_RECV) || (state_d == S_CHECK);
    we_d       = (state_d == S_WRITE);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      byte_cnt_q  <= '0;
      word_cnt_q  <= '0;
      mem_addr_q  <= ADDR_WIDTH'(BASE_ADDR);
      wdata_q     <= '0;
      sum_q       <= '0;
      in_ready_q  <= 1'b0;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cksum_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      word_cnt_q  <= word_cnt_d;
      mem_addr_q  <= mem_addr_d;
      wdata_q     <= wdata_d;
      sum_q       <= sum_d;
      in_ready_q  <= in_ready_d;
      we_q        <= we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cksum_err_q <= cksum_err_d;
    end
  end

  // The RAM samples the strobe at the closing edge of the WRITE cycle, so abort or reset arriving
  // in that same cycle must suppress it before the edge.
  assign mem_we    = we_q && !abort && !reset;
  assign in_ready  = in_ready_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cksum_err = cksum_err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_nn_weight_loader.sv
// Bench for nn_weight_loader: table of load scenarios plus randomized loads, checked against a
// byte-list model of the RAM image, checksum and handshake-derived timing.
module tb_nn_weight_loader;

  localparam int BASE = 0;

  logic         clk = 1'b0;
  logic         reset, start, abort, in_valid;
  logic [7:0]   in_data;
  logic         in_ready, mem_we, busy, done, cksum_err;
  logic [3:0]   mem_addr;
  logic [255:0] mem_wdata;
  logic [2:0]   state_dbg;

  nn_weight_loader dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .busy(busy), .done(done), .cksum_err(cksum_err), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scenario record: fill 0=ramp 1=0x81 2=random; gap 0=none 1=1,0,0 2=random;
  // action 0=none 1=abort 2=reset 3=start pulse, applied once stop_at bytes are accepted
  typedef struct {
    int fill; int gap; int bad; int action; int stop_at;
    int exp_nwr; int exp_done; int exp_err;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [255:0] exp_q[$];
  int           exp_cyc_q[$];
  logic [255:0] exp_word[0:1];
  logic [255:0] ram[0:15];
  logic [7:0]   stream[0:64];
  int           hs_cyc[0:64];
  int           wr_cyc[0:3];
  int           wr_idx = 0;
  int           done_cnt = 0;
  int           done_cyc = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // scoreboard: the RAM side, sampled mid-cycle
  always @(negedge clk) begin
    if (mem_we) begin
      ram[mem_addr] = mem_wdata;
      if (wr_idx < 4) wr_cyc[wr_idx] = cyc;
      chk("wr_addr", 256'(mem_addr), 256'(BASE + wr_idx));
      chk("wr_expected", 256'(exp_q.size() != 0), 256'(1));
      if (exp_q.size() != 0) chk("wr_data", mem_wdata, exp_q.pop_front());
      chk("wr_not_early", 256'(exp_cyc_q.size() != 0), 256'(1));
      if (exp_cyc_q.size() != 0) chk("wr_cycle", 256'(cyc), 256'(exp_cyc_q.pop_front()));
      wr_idx++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // driver: one full scenario
  task automatic run_row(input vec_t v);
    int sum, idx, t, cur, s;
    bit stopped, hs, vld, acted;
    sum = 0;
    for (int i = 0; i < 64; i++) begin
      if (v.fill == 0)      stream[i] = 8'(i);
      else if (v.fill == 1) stream[i] = 8'h81;
      else                  stream[i] = 8'($urandom_range(0, 255));
      sum += int'(stream[i]);
    end
    stream[64] = 8'(sum + v.bad);
    exp_q.delete();
    exp_cyc_q.delete();
    wr_idx = 0;
    done_cnt = 0;
    for (int a = 0; a < 16; a++) ram[a] = '0;
    for (int w = 0; w < 2; w++) begin
      exp_word[w] = '0;
      for (int k = 0; k < 32; k++) exp_word[w][8*k +: 8] = stream[32*w + k];
      if (w < v.exp_nwr) exp_q.push_back(exp_word[w]);
    end

    @(posedge clk); #1;
    start = 1'b1;
    s = cyc;
    @(posedge clk); #1;
    start = 1'b0;

    idx = 0; t = 0; stopped = 0; acted = 0;
    while (!stopped && idx < 65 && t < 400) begin
      cur = cyc;
      if (v.action != 0 && idx == v.stop_at && !acted) begin
        acted = 1;
        if (v.action == 1) begin abort = 1'b1; stopped = 1; end
        if (v.action == 2) begin reset = 1'b1; stopped = 1; end
        if (v.action == 3) start = 1'b1;
      end
      if (stopped) begin
        in_valid = 1'b0;
      end else begin
        if (v.gap == 0)      vld = 1;
        else if (v.gap == 1) vld = (t % 3 == 0);
        else                 vld = 1'($urandom_range(0, 1));
        in_valid = vld;
        in_data  = stream[idx];
      end
      @(negedge clk);
      if (t == 0) begin
        chk("err_cleared_on_start", 256'(cksum_err), 256'(0));
        chk("busy_in_load", 256'(busy), 256'(1));
      end
      if (stopped) chk("we_blocked", 256'(mem_we), 256'(0));
      hs = in_valid && in_ready;
      if (hs) begin
        hs_cyc[idx] = cur;
        if (idx < 64 && idx % 32 == 31) exp_cyc_q.push_back(cur + 1);
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (hs) idx++;
      t++;
    end
    in_valid = 1'b0;
    abort = 1'b0;
    reset = 1'b0;

    if (stopped) begin
      chk("bytes_before_stop", 256'(idx), 256'(v.stop_at));
      @(negedge clk);
      chk("stop_busy", 256'(busy), 256'(0));
      chk("stop_ready", 256'(in_ready), 256'(0));
      chk("stop_done", 256'(done), 256'(0));
      if (v.action == 2) begin
        chk("rst_addr", 256'(mem_addr), 256'(BASE));
        chk("rst_wdata", mem_wdata, 256'(0));
        chk("rst_err", 256'(cksum_err), 256'(0));
        chk("rst_we", 256'(mem_we), 256'(0));
      end
      repeat (2) @(posedge clk);
      #1;
    end else begin
      chk("bytes_accepted", 256'(idx), 256'(65));
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("busy_after", 256'(busy), 256'(0));
    end

    chk("done_count", 256'(done_cnt), 256'(v.exp_done));
    if (v.exp_done != 0 && !stopped) chk("done_cycle", 256'(done_cyc), 256'(hs_cyc[64] + 1));
    chk("write_count", 256'(wr_idx), 256'(v.exp_nwr));
    chk("writes_missing", 256'(exp_q.size()), 256'(0));
    chk("cksum_err", 256'(cksum_err), 256'(v.exp_err));
    for (int w = 0; w < 2; w++)
      chk("ram_word", ram[BASE + w], (w < v.exp_nwr) ? exp_word[w] : 256'(0));
    if (v.gap == 0 && v.action != 1 && v.action != 2 && wr_idx == 2) begin
      chk("we0_latency", 256'(wr_cyc[0] - s), 256'(33));
      chk("we1_latency", 256'(wr_cyc[1] - s), 256'(66));
      chk("done_latency", 256'(done_cyc - s), 256'(68));
    end
  endtask

  vec_t vecs[8];

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
    vecs[0] = '{0, 0, 0, 0, 0,  2, 1, 0};  // nominal ramp, checksum 0xE0
    vecs[1] = '{0, 0, 1, 0, 0,  2, 1, 1};  // checksum 0xE1
    vecs[2] = '{1, 1, 0, 0, 0,  2, 1, 0};  // 0x81 with 1,0,0 valid pattern
    vecs[3] = '{0, 0, 0, 1, 40, 1, 0, 0};  // abort after 40 bytes
    vecs[4] = '{2, 0, 0, 0, 0,  2, 1, 0};  // full reload after abort
    vecs[5] = '{2, 0, 0, 2, 64, 1, 0, 0};  // reset in word-1 WRITE cycle
    vecs[6] = '{2, 0, 0, 3, 10, 2, 1, 0};  // start pulsed mid-RECV
    vecs[7] = '{2, 2, 1, 0, 0,  2, 1, 1};  // random gaps, bad checksum

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_ready", 256'(in_ready), 256'(0));
    chk("reset_we", 256'(mem_we), 256'(0));
    chk("reset_addr", 256'(mem_addr), 256'(BASE));
    chk("reset_wdata", mem_wdata, 256'(0));
    chk("reset_busy", 256'(busy), 256'(0));
    chk("reset_done", 256'(done), 256'(0));
    chk("reset_err", 256'(cksum_err), 256'(0));
    @(posedge clk); #1;
    reset = 1'b0;

    // start and abort together in IDLE, with in_valid high while idle
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1; in_valid = 1'b1; in_data = 8'h55;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_busy", 256'(busy), 256'(0));
      chk("idle_ready", 256'(in_ready), 256'(0));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("idle_no_write", 256'(wr_idx), 256'(0));

    for (int r = 0; r < 8; r++) run_row(vecs[r]);

    for (int r = 0; r < 6; r++) begin
      vec_t v;
      v.fill = 2; v.gap = $urandom_range(0, 2); v.bad = $urandom_range(0, 1);
      v.action = 0; v.stop_at = 0; v.exp_nwr = 2; v.exp_done = 1; v.exp_err = v.bad;
      run_row(v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
